// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and arbiter state encoding for the UART transmit path
package uart_pkg;
  localparam int W_OUT = 24;
  localparam int BITS_PER_WORD = 8;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_LOW, WAIT_HIGH} tx_arb_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the TX arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W_OUT = uart_pkg::W_OUT
);
  localparam int SW = uart_pkg::idx_w(N_REQ);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*W_OUT-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   m_valid;
  logic [W_OUT-1:0]       m_data;
  logic                   m_ready;
  logic [SW-1:0]          m_src;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  modport master (
    input  req_valid, req_data, m_ready,
    output req_ready, m_valid, m_data, m_src, done, busy
  );
  modport slave (
    output req_valid, req_data, m_ready,
    input  req_ready, m_valid, m_data, m_src, done, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last served index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = uart_pkg::idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  logic [IW-1:0] j;
  logic [IW:0]   sum;
  // rotate so the search origin sits at bit 0, then take the lowest set bit
  always_comb begin
    start = (int'(last) == N - 1) ? '0 : last + 1'b1;
    rot = N'({req, req} >> start);
    j = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) j = IW'(k);
    sum = {1'b0, start} + {1'b0, j};
    grant_idx = (int'(sum) >= N) ? IW'(int'(sum) - N) : sum[IW-1:0];
    any = |req;
    grant = any ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART frame transmitter among N_REQ producers
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int W_OUT = uart_pkg::W_OUT,
  parameter int BITS_PER_WORD = uart_pkg::BITS_PER_WORD
) (
  input logic clk,
  input logic rstn,
  uart_tx_arbiter_if.master bus
);
  import uart_pkg::*;
  localparam int SW = idx_w(N_REQ);
  if (N_REQ < 1 || W_OUT % BITS_PER_WORD != 0) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be >= 1 and W_OUT a multiple of BITS_PER_WORD");
  end
  tx_arb_state_e    state_q, state_d;
  logic [W_OUT-1:0] buf_q, buf_d;
  logic [SW-1:0]    src_q, src_d, last_q, last_d, grant_idx;
  logic [N_REQ-1:0] done_q, done_d, grant;
  logic             any;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(bus.req_valid), .last(last_q), .grant(grant), .grant_idx(grant_idx), .any(any)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    src_d = src_q;
    last_d = last_q;
    done_d = '0;
    case (state_q)
      IDLE: if (any) begin
        state_d = OFFER;
        buf_d = bus.req_data[int'(grant_idx)*W_OUT +: W_OUT];
        src_d = grant_idx;
      end
      OFFER: if (bus.m_ready) state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.m_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (bus.m_ready) begin
        state_d = IDLE;
        last_d = src_q;
        done_d = N_REQ'(1) << src_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      buf_q <= '0;
      src_q <= '0;
      last_q <= SW'(N_REQ - 1);
      done_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      src_q <= src_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end
  // the strobe is gated by rstn so no capture is advertised while held in reset
  assign bus.req_ready = (state_q == IDLE && rstn) ? grant : '0;
  assign bus.m_valid = state_q == OFFER;
  assign bus.m_data = buf_q;
  assign bus.m_src = src_q;
  assign bus.done = done_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of the round-robin UART TX arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 24;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  int tx_len = 156;
  bit hold = 1'b0;
  int tx_cnt = 0;
  bit prev_valid = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [1:0] prev_src = '0;
  logic [W-1:0] acc_data_q[$];
  int acc_src_q[$];
  int acc_rd = 0;
  int last_m = N - 1;
  logic [W-1:0] ref_data [N];
  int cnt1 = 0, cyc1 = 0, rise1 = 0;
  bit prev1 = 1'b0;
  logic [W-1:0] prev1_data = '0;
  logic [W-1:0] acc1_q[$];
  int gap1_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .W_OUT(W)) bus ();
  uart_tx_arbiter_if #(.N_REQ(1), .W_OUT(W)) bus1 ();
  uart_tx_arbiter #(.N_REQ(N), .W_OUT(W)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));
  uart_tx_arbiter #(.N_REQ(1), .W_OUT(W)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1.master));

  // transmitter model: ready while idle, low for tx_len cycles after accepting a frame
  always @(negedge clk) begin
    if (!rstn) tx_cnt = 0;
    else if (prev_valid && bus.m_ready === 1'b1) begin
      acc_data_q.push_back(prev_data);
      acc_src_q.push_back(int'(prev_src));
      tx_cnt = tx_len;
    end else if (tx_cnt > 0) tx_cnt--;
    bus.m_ready = (tx_cnt == 0) && !hold;
    prev_valid = bus.m_valid;
    prev_data = bus.m_data;
    prev_src = bus.m_src;
  end

  // second transmitter for the single-requester build; logs idle cycles before each accept
  always @(negedge clk) begin
    cyc1++;
    if (!rstn) cnt1 = 0;
    else if (prev1 && bus1.m_ready === 1'b1) begin
      acc1_q.push_back(prev1_data);
      gap1_q.push_back(cyc1 - rise1 - 1);
      cnt1 = 10;
    end else if (cnt1 > 0) cnt1--;
    if (cnt1 == 0 && bus1.m_ready !== 1'b1) rise1 = cyc1;
    bus1.m_ready = cnt1 == 0;
    prev1 = bus1.m_valid;
    prev1_data = bus1.m_data;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    bus.req_data[i*W +: W] = d;
    ref_data[i] = d;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last_m + k) % N]) return (last_m + k) % N;
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_src"}, bus.m_src, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    tick();
    while (bus.done === '0 && n < 4000) begin
      tick();
      n++;
    end
    chk("done_timeout", n < 4000, 1);
  endtask

  task automatic wait_level(input logic b);
    int n = 0;
    while (bus.m_ready !== b && n < 4000) begin
      tick();
      n++;
    end
    chk("m_ready_timeout", n < 4000, 1);
  endtask

  task automatic expect_frame(input int w, input logic [W-1:0] data, input string tag);
    chk({tag, "_done"}, bus.done, 64'(1) << w);
    chk({tag, "_acc_cnt"}, acc_data_q.size() > acc_rd, 1);
    if (acc_data_q.size() > acc_rd) begin
      chk({tag, "_acc_src"}, acc_src_q[acc_rd], w);
      chk({tag, "_acc_data"}, acc_data_q[acc_rd], data);
      acc_rd++;
    end
    last_m = w;
  endtask

  initial begin
    logic [N-1:0] v;
    logic [W-1:0] cap;
    int w, n;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus1.req_valid = '0;
    bus1.req_data = '0;
    for (int i = 0; i < N; i++) set_data(i, W'(24'hA00000 + i));
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    check_zero("reset");
    rstn = 1'b1;
    #1;
    chk("first_grant", bus.req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_done();
      w = pick(4'b1111);
      expect_frame(w, ref_data[w], "rr");
    end
    bus.req_valid = '0;
    #1;
    chk("rr_stop", bus.req_ready, 0);
    tick();
    chk("rr_idle", bus.busy, 0);

    tx_len = 20;
    set_data(2, 24'h123456);
    bus.req_valid = 4'b0100;
    #1;
    w = pick(4'b0100);
    chk("single_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    chk("single_valid", bus.m_valid, 1);
    chk("single_data", bus.m_data, 24'h123456);
    chk("single_src", bus.m_src, 2);
    wait_level(1'b0);
    wait_level(1'b1);
    tick();
    expect_frame(w, 24'h123456, "single");
    tick();
    chk("single_pulse", bus.done, 0);
    chk("single_busy", bus.busy, 0);

    hold = 1'b1;
    tick();
    cap = W'($urandom);
    set_data(2, cap);
    bus.req_valid = 4'b0100;
    #1;
    w = pick(4'b0100);
    chk("hold_ready", bus.req_ready, 64'(1) << w);
    tick();
    bus.req_valid = '0;
    bus.req_data[2*W +: W] = 24'hFFFFFF;
    for (int k = 0; k < 50; k++) begin
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_data", bus.m_data, cap);
      tick();
    end
    hold = 1'b0;
    wait_done();
    expect_frame(w, cap, "hold");

    tx_len = 40;
    set_data(1, W'($urandom));
    bus.req_valid = 4'b0010;
    #1;
    w = pick(4'b0010);
    chk("abort_ready", bus.req_ready, 64'(1) << w);
    tick();
    bus.req_valid = '0;
    wait_level(1'b0);
    repeat (3) tick();
    chk("abort_busy", bus.busy, 1);
    chk("abort_m_valid", bus.m_valid, 0);
    rstn = 1'b0;
    bus.req_valid = 4'b1001;
    #1;
    check_zero("rst_mid");
    repeat (3) begin
      tick();
      chk("rst_no_done", bus.done, 0);
    end
    acc_rd = acc_data_q.size();
    last_m = N - 1;
    set_data(0, W'($urandom));
    set_data(3, W'($urandom));
    rstn = 1'b1;
    #1;
    w = pick(4'b1001);
    chk("post_rst_ready", bus.req_ready, 64'(1) << w);
    cap = ref_data[w];
    tick();
    bus.req_valid = '0;
    wait_done();
    expect_frame(w, cap, "post_rst");

    tx_len = 30;
    set_data(3, W'($urandom));
    set_data(1, W'($urandom));
    bus.req_valid = 4'b1000;
    #1;
    w = pick(4'b1000);
    chk("late_ready3", bus.req_ready, 64'(1) << w);
    cap = ref_data[w];
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chk("late_no_grant", bus.req_ready, 0);
    wait_done();
    expect_frame(w, cap, "late3");
    w = pick(4'b0010);
    chk("late_ready1", bus.req_ready, 64'(1) << w);
    cap = ref_data[w];
    tick();
    bus.req_valid = '0;
    wait_done();
    expect_frame(w, cap, "late1");

    for (int r = 0; r < 24; r++) begin
      tx_len = $urandom_range(2, 12);
      for (int i = 0; i < N; i++) set_data(i, W'($urandom));
      v = N'($urandom_range(1, 15));
      bus.req_valid = v;
      #1;
      w = pick(v);
      chk("rand_ready", bus.req_ready, 64'(1) << w);
      cap = ref_data[w];
      tick();
      bus.req_valid = '0;
      wait_done();
      expect_frame(w, cap, "rand");
    end

    bus1.req_data = 24'h0000AA;
    bus1.req_valid = 1'b1;
    n = 0;
    while (acc1_q.size() < 1 && n < 200) begin
      tick();
      n++;
    end
    bus1.req_data = 24'h0000BB;
    while (acc1_q.size() < 2 && n < 400) begin
      tick();
      n++;
    end
    bus1.req_valid = 1'b0;
    chk("n1_frames", acc1_q.size(), 2);
    if (acc1_q.size() == 2) begin
      chk("n1_first", acc1_q[0], 24'h0000AA);
      chk("n1_second", acc1_q[1], 24'h0000BB);
      chk("n1_gap", gap1_q[1], 2);
    end
    chk("n1_src", bus1.m_src, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
